// File: rtl/fifo_bank_pkg.sv
// Shared types and width helpers for the fifo_bank FIFO array.
// Optional err port and logic are enabled by FIFO_BANK_ERR_EN.
package fifo_bank_pkg;

   typedef enum logic {IDLE, DRAIN} fb_state_t;

   localparam int FB_NUM_FIFOS  = 9;
   localparam int FB_DEPTH      = 8;
   localparam int FB_DATA_WIDTH = 8;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Single FIFO of the bank; write to full and read from empty are ignored.
// Storage is not reset, only pointers and count.
module byte_fifo
   import fifo_bank_pkg::*;
#(
   parameter int DEPTH      = FB_DEPTH,
   parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      rd_en,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;
   logic                  do_wr;
   logic                  do_rd;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fifo_bank.sv
// Bank of byte FIFOs: filled by feed_from_mem, drained in lockstep.
// Define FIFO_BANK_ERR_EN to add the sticky err output.
module fifo_bank
   import fifo_bank_pkg::*;
#(
   parameter int NUM_FIFOS  = FB_NUM_FIFOS,
   parameter int DEPTH      = FB_DEPTH,
   parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DATA_WIDTH-1:0]           dataByte,
   input  logic [NUM_FIFOS-1:0]            fifoEnable,
   input  logic                            drain,
   output logic                            allFull,
   output logic                            busy,
   output logic [NUM_FIFOS*DATA_WIDTH-1:0] outVec,
   output logic                            outValid,
   output logic                            done
`ifdef FIFO_BANK_ERR_EN
   ,
   output logic                            err
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   fb_state_t                       state;
   logic [PW-1:0]                   pop_cnt;
   logic [CW-1:0]                   cnt [NUM_FIFOS];
   logic [NUM_FIFOS-1:0]            cnt_full;
   logic [NUM_FIFOS-1:0]            full_v;
   logic [NUM_FIFOS-1:0]            empty_v;
   logic [NUM_FIFOS*DATA_WIDTH-1:0] rd_vec;
   logic                            wr_ok;
   logic                            rd_go;
   logic                            start;
   logic                            last_pop;
   logic                            unused_flags;

   assign wr_ok    = (state == IDLE);
   assign rd_go    = (state == DRAIN);
   assign start    = wr_ok & drain & allFull;
   assign last_pop = rd_go & (pop_cnt == PW'(DEPTH - 1));
   assign allFull  = &cnt_full;
   assign busy     = rd_go;

   assign unused_flags = ^{full_v, empty_v};

   for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_fifo
      byte_fifo #(
         .DEPTH      (DEPTH),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (fifoEnable[gi] & wr_ok),
         .wr_data (dataByte),
         .rd_en   (rd_go),
         .rd_data (rd_vec[gi*DATA_WIDTH +: DATA_WIDTH]),
         .count   (cnt[gi]),
         .full    (full_v[gi]),
         .empty   (empty_v[gi])
      );
      assign cnt_full[gi] = (cnt[gi] == CW'(DEPTH));
   end

   // outValid/done trail the pop by one cycle; done lands on the first IDLE cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pop_cnt  <= '0;
         outVec   <= '0;
         outValid <= 1'b0;
         done     <= 1'b0;
      end else begin
         outValid <= rd_go;
         done     <= last_pop;
         if (rd_go) outVec <= rd_vec;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= DRAIN;
                  pop_cnt <= '0;
               end
            end
            DRAIN: begin
               pop_cnt <= pop_cnt + 1'b1;
               if (last_pop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_BANK_ERR_EN
   logic drop;

   assign drop = (wr_ok & |(fifoEnable & full_v))
               | (rd_go & |fifoEnable)
               | (wr_ok & drain & ~allFull);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else if (drop) begin
         err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_bank.sv
// Randomized bench for fifo_bank against a queue-based reference model.
// Build with or without FIFO_BANK_ERR_EN.
module tb_fifo_bank;

   localparam int NF = 9;
   localparam int D  = 8;
   localparam int DW = 8;

   logic           clk;
   logic           rst_n;
   logic [DW-1:0]  dataByte;
   logic [NF-1:0]  fifoEnable;
   logic           drain;
   logic           allFull;
   logic           busy;
   logic [NF*DW-1:0] outVec;
   logic           outValid;
   logic           done;
`ifdef FIFO_BANK_ERR_EN
   logic           err;
`endif

   int total = 0;
   int bad   = 0;

   fifo_bank #(
      .NUM_FIFOS  (NF),
      .DEPTH      (D),
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dataByte   (dataByte),
      .fifoEnable (fifoEnable),
      .drain      (drain),
      .allFull    (allFull),
      .busy       (busy),
      .outVec     (outVec),
      .outValid   (outValid),
      .done       (done)
`ifdef FIFO_BANK_ERR_EN
      ,
      .err        (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: one queue per FIFO plus drain bookkeeping
   logic [DW-1:0]    q [NF][$];
   bit               m_drain;
   int               m_beats;
   logic [NF*DW-1:0] e_vec;
   logic             e_valid;
   logic             e_done;
   logic             e_err;

   function automatic bit m_allfull();
      for (int i = 0; i < NF; i++)
         if (q[i].size() != D) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [NF-1:0] need_mask(input logic [NF-1:0] short_mask);
      logic [NF-1:0] m;
      m = '0;
      for (int i = 0; i < NF; i++)
         m[i] = q[i].size() < (short_mask[i] ? D - 1 : D);
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit af;
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) q[i].delete();
         m_drain = 0;
         m_beats = 0;
         e_vec   = '0;
         e_valid = 0;
         e_done  = 0;
         e_err   = 0;
      end else if (!m_drain) begin
         af = m_allfull();
         e_valid = 0;
         e_done  = 0;
         for (int i = 0; i < NF; i++)
            if (fifoEnable[i]) begin
               if (q[i].size() < D) q[i].push_back(dataByte);
               else e_err = 1;
            end
         if (drain) begin
            if (af) begin
               m_drain = 1;
               m_beats = 0;
            end else begin
               e_err = 1;
            end
         end
      end else begin
         for (int i = 0; i < NF; i++) e_vec[i*DW +: DW] = q[i].pop_front();
         e_valid = 1;
         if (|fifoEnable) e_err = 1;
         m_beats++;
         e_done = (m_beats == D);
         if (e_done) m_drain = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill(input logic [NF-1:0] short_mask);
      logic [NF-1:0] need;
      int guard;
      guard = 0;
      need  = need_mask(short_mask);
      while (need != '0 && guard < 400) begin
         fifoEnable = NF'($urandom) & need;
         dataByte   = DW'($urandom);
         tick();
         fifoEnable = '0;
         need = need_mask(short_mask);
         guard++;
      end
      total++;
      if (need != '0) begin
         bad++;
         $display("FAIL fill_timeout need=%h required=0", need);
      end
   endtask

   task automatic run_drain(input bit pat, input int wr_beat, input int rst_beat);
      int beats;
      bit fin;
      logic [DW-1:0] eb;
      beats = 0;
      fin   = 0;
      drain = 1'b1;
      tick();
      drain = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL drain_start busy=%b required=1", busy);
      end
      for (int c = 0; c < D + 4 && !fin; c++) begin
         tick();
         fifoEnable = '0;
         total += 4;
         if (outValid !== e_valid) begin
            bad++;
            $display("FAIL outValid got=%b required=%b", outValid, e_valid);
         end
         if (done !== e_done) begin
            bad++;
            $display("FAIL done got=%b required=%b", done, e_done);
         end
         if (busy !== m_drain) begin
            bad++;
            $display("FAIL busy got=%b required=%b", busy, m_drain);
         end
         if (outVec !== e_vec) begin
            bad++;
            $display("FAIL outVec got=%h required=%h", outVec, e_vec);
         end
`ifdef FIFO_BANK_ERR_EN
         total++;
         if (err !== e_err) begin
            bad++;
            $display("FAIL err got=%b required=%b", err, e_err);
         end
`endif
         if (outValid === 1'b1) begin
            beats++;
            if (pat) begin
               for (int i = 0; i < NF; i++) begin
                  eb = 8'hA0 + DW'((beats - 1) * NF + i);
                  total++;
                  if (outVec[i*DW +: DW] !== eb) begin
                     bad++;
                     $display("FAIL pattern beat=%0d fifo=%0d got=%h required=%h",
                              beats, i, outVec[i*DW +: DW], eb);
                  end
               end
            end
         end
         if (done === 1'b1) begin
            fin = 1;
            total++;
            if (beats != D) begin
               bad++;
               $display("FAIL done_beat got=%0d required=%0d", beats, D);
            end
         end
         if (outValid === 1'b1 && beats == wr_beat) fifoEnable = '1;
         if (outValid === 1'b1 && beats == rst_beat) begin
            #2 rst_n = 1'b0;
            #1;
            total++;
            if ({outValid, busy, done, allFull} !== 4'b0) begin
               bad++;
               $display("FAIL reset_abort vbda=%b required=0000",
                        {outValid, busy, done, allFull});
            end
            @(negedge clk);
            rst_n = 1'b1;
            fin = 1;
         end
      end
      total++;
      if (!fin) begin
         bad++;
         $display("FAIL drain_timeout beats=%0d", beats);
      end
      total++;
      if (allFull !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL drain_end allFull=%b busy=%b required=0 0", allFull, busy);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      dataByte   = '0;
      fifoEnable = '0;
      drain      = 1'b0;
      repeat (2) @(negedge clk);
      total += 2;
      if ({outValid, busy, done, allFull} !== 4'b0) begin
         bad++;
         $display("FAIL reset_flags vbda=%b required=0000",
                  {outValid, busy, done, allFull});
      end
      if (outVec !== '0) begin
         bad++;
         $display("FAIL reset_outVec got=%h required=0", outVec);
      end
`ifdef FIFO_BANK_ERR_EN
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL reset_err got=%b required=0", err);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int n = 0; n < NF * D; n++) begin
         fifoEnable = NF'(1) << (n % NF);
         dataByte   = 8'hA0 + DW'(n);
         tick();
         total += 2;
         if (outValid !== 1'b0) begin
            bad++;
            $display("FAIL fill_outValid n=%0d got=%b required=0", n, outValid);
         end
         if (allFull !== (n == NF * D - 1)) begin
            bad++;
            $display("FAIL fill_allFull n=%0d got=%b required=%b",
                     n, allFull, n == NF * D - 1);
         end
      end
      fifoEnable = '0;
   endtask

   task automatic test_drain();
      run_drain(1'b1, -1, -1);
   endtask

   task automatic test_overflow();
      fill('0);
      fifoEnable = NF'(1);
      dataByte   = 8'hFF;
      tick();
      fifoEnable = '0;
`ifdef FIFO_BANK_ERR_EN
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL overflow_err got=%b required=1", err);
      end
`endif
      run_drain(1'b0, -1, -1);
   endtask

   task automatic test_partial();
      fill(NF'(1) << 4);
      drain = 1'b1;
      repeat (3) begin
         tick();
         total++;
         if ({busy, outValid, allFull} !== 3'b0) begin
            bad++;
            $display("FAIL partial_idle bva=%b required=000",
                     {busy, outValid, allFull});
         end
      end
      drain      = 1'b0;
      fifoEnable = NF'(1) << 4;
      dataByte   = DW'($urandom);
      tick();
      fifoEnable = '0;
      total++;
      if (allFull !== 1'b1) begin
         bad++;
         $display("FAIL partial_complete allFull=%b required=1", allFull);
      end
      run_drain(1'b0, -1, -1);
   endtask

   task automatic test_drain_write();
      fill('0);
      run_drain(1'b0, 3, -1);
      for (int k = 0; k < D; k++) begin
         fifoEnable = '1;
         dataByte   = DW'($urandom);
         tick();
         total++;
         if (allFull !== (k == D - 1)) begin
            bad++;
            $display("FAIL refill k=%0d allFull=%b required=%b",
                     k, allFull, k == D - 1);
         end
      end
      fifoEnable = '0;
      run_drain(1'b0, -1, -1);
   endtask

   task automatic test_reset_mid();
      fill('0);
      run_drain(1'b0, -1, 5);
      fill('0);
      run_drain(1'b0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_overflow();
      test_partial();
      test_drain_write();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
